lsu_mem_requester: RTL and testbench

- Initiator side of the CPU data-memory port.
- Accepts one load/store request at a time from the execute stage and drives the Mem port's request signals: addr, wdata, mask, enable, wen. Returns formatted load data to writeback.
- Handles byte-lane steering, mask generation, sign/zero extension and the Mem port's one-cycle registered read latency.
- Sits between EXU and the Mem block; Mem performs the DPI-C access on the clock edge where enable is high.

---
 rtl/lsu_mem_requester_if.sv | 39 +++
 rtl/lsu_mem_requester.sv | 143 ++++++++++++++
 tb/tb_lsu_mem_requester.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_requester_if.sv
// Bundles the EXU request/response channel and the Mem port of the LSU requester.
// The master view belongs to the requester; the slave view to the EXU/writeback and Mem side.
interface lsu_mem_requester_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_mask;
    logic              mem_enable;
    logic              mem_wen;
    logic [63:0]       mem_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_data;
    logic              resp_err;

    modport master (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata, resp_ready,
        output req_ready, mem_addr, mem_wdata, mem_mask, mem_enable, mem_wen,
        output resp_valid, resp_data, resp_err
    );

    modport slave (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata, resp_ready,
        input  req_ready, mem_addr, mem_wdata, mem_mask, mem_enable, mem_wen,
        input  resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/lsu_mem_requester.sv
// Data-memory requester: one load/store at a time, lane steering, load extension.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_requester #(
    parameter int ADDR_W     = 64,
    parameter bit ALIGN_ADDR = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    lsu_mem_requester_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic              store_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [2:0]        off_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [63:0]       mem_wdata_q;
    logic [7:0]        mem_mask_q;
    logic [63:0]       resp_data_q, resp_data_d;

    logic              accept;
    logic [7:0]        base_mask;
    logic [63:0]       load_shifted;
    logic [63:0]       load_ext;

    assign accept = (state_q == IDLE) && bus.req_valid && !reset;

`ifdef LSU_MISALIGN_TRAP_EN
    logic       resp_err_q, resp_err_d;
    logic [2:0] align_bits;
    logic       misaligned;

    always_comb begin
        case (bus.req_size)
            2'd0:    align_bits = 3'b000;
            2'd1:    align_bits = 3'b001;
            2'd2:    align_bits = 3'b011;
            default: align_bits = 3'b111;
        endcase
    end
    assign misaligned   = |(bus.req_addr[2:0] & align_bits);
    assign resp_err_d   = accept ? misaligned : resp_err_q;
    assign bus.resp_err = resp_err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = misaligned ? RESP : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE:   state_d = store_q ? RESP : WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (bus.req_size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    // Lanes above the addressed byte shift in as zero before extension.
    assign load_shifted = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    load_ext = {{56{signed_q & load_shifted[7]}},  load_shifted[7:0]};
            2'd1:    load_ext = {{48{signed_q & load_shifted[15]}}, load_shifted[15:0]};
            2'd2:    load_ext = {{32{signed_q & load_shifted[31]}}, load_shifted[31:0]};
            default: load_ext = load_shifted;
        endcase
    end

    always_comb begin
        resp_data_d = resp_data_q;
        if (accept) begin
            resp_data_d = '0;
        end else if (state_q == WAIT) begin
            resp_data_d = load_ext;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: datapath registers are reset too because mem_* and resp_data are observable right after reset.
            state_q     <= IDLE;
            store_q     <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= 2'd0;
            off_q       <= 3'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            resp_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_err_q  <= resp_err_d;
`endif
            if (accept) begin
                store_q     <= bus.req_store;
                signed_q    <= bus.req_signed;
                size_q      <= bus.req_size;
                off_q       <= bus.req_addr[2:0];
                mem_addr_q  <= ALIGN_ADDR ? {bus.req_addr[ADDR_W-1:3], 3'b000} : bus.req_addr;
                mem_wdata_q <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
                mem_mask_q  <= base_mask << bus.req_addr[2:0];
            end
        end
    end

    // Enables are gated by reset so a reset landing in ISSUE causes no memory side effect.
    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign bus.mem_enable = (state_q == ISSUE) && !reset;
    assign bus.mem_wen    = (state_q == ISSUE) && store_q && !reset;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_mask   = mem_mask_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_lsu_mem_requester.sv
// Self-checking bench for lsu_mem_requester: directed test-plan cases plus randomized
// transactions checked against a byte-lane reference model.
module tb_lsu_mem_requester;
    localparam int ADDR_W = 64;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    lsu_mem_requester_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_mem_requester #(.ADDR_W(ADDR_W), .ALIGN_ADDR(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Observations from one transaction, filled in by run_txn.
    typedef struct {
        bit          ready_at_req;
        int          en_count;
        logic [63:0] addr;
        logic [7:0]  mask;
        logic [63:0] wdata;
        logic        wen;
        int          latency;
        logic [63:0] data;
        logic        err;
        bit          stable;
        bit          ready_low;
        bit          idle_after;
        bit          timeout;
    } obs_t;
    obs_t obs;

    // Reference model: byte-lane view of the Mem port.
    function automatic logic [7:0] m_mask(input int size, input int off);
        logic [7:0] m = '0;
        for (int k = 0; k < (1 << size); k++) if (off + k < 8) m[off + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input int off);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) if (i >= off) v[8*i +: 8] = wd[8*(i - off) +: 8];
        return v;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input int size, input int off, input bit sg);
        logic [63:0] v = '0;
        int n = 1 << size;
        for (int k = 0; k < n; k++) if (off + k < 8) v[8*k +: 8] = rd[8*(off + k) +: 8];
        if (sg && v[8*n - 1]) for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
        return v;
    endfunction

    function automatic bit m_misaligned(input logic [63:0] addr, input int size);
        return (addr % (64'd1 << size)) != 0;
    endfunction

    task automatic sample_mem_stability();
        if (obs.en_count > 0 &&
            (bus.mem_addr !== obs.addr || bus.mem_mask !== obs.mask || bus.mem_wdata !== obs.wdata))
            obs.stable = 1'b0;
    endtask

    // Drives one request, plays Mem (rdata valid the cycle after enable) and writeback.
    task automatic run_txn(input logic st, input logic [1:0] sz, input logic sg, input logic [63:0] ad,
                           input logic [63:0] wd, input logic [63:0] rd, input int hold);
        int cyc;
        bit prev_en;
        bit done;
        obs = '{default: 0};
        obs.latency = -1; obs.stable = 1'b1; obs.ready_low = 1'b1;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = ad; bus.req_wdata = wd;
        obs.ready_at_req = bus.req_ready;
        @(negedge clock);
        bus.req_valid = 1'b0; bus.req_store = 1'($urandom); bus.req_size = 2'($urandom);
        bus.req_signed = 1'($urandom); bus.req_addr = {$urandom, $urandom}; bus.req_wdata = {$urandom, $urandom};
        cyc = 1; prev_en = 1'b0; done = 1'b0;
        while (!done && cyc < 30) begin
            if (bus.mem_enable) begin
                obs.en_count++;
                obs.addr = bus.mem_addr; obs.mask = bus.mem_mask; obs.wdata = bus.mem_wdata; obs.wen = bus.mem_wen;
                bus.mem_rdata = rd;
                prev_en = 1'b1;
            end else begin
                if (!prev_en) bus.mem_rdata = {$urandom, $urandom};
                prev_en = 1'b0;
            end
            sample_mem_stability();
            if (bus.resp_valid) begin
                obs.latency = cyc; obs.data = bus.resp_data; obs.err = bus.resp_err;
                if (bus.req_ready) obs.ready_low = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clock); cyc++;
                    if (!bus.resp_valid || bus.resp_data !== obs.data || bus.resp_err !== obs.err) obs.stable = 1'b0;
                    if (bus.req_ready) obs.ready_low = 1'b0;
                    if (bus.mem_enable) obs.en_count++;
                    sample_mem_stability();
                end
                bus.resp_ready = 1'b1;
                @(negedge clock);
                bus.resp_ready = 1'b0;
                obs.idle_after = bus.req_ready && !bus.resp_valid;
                if (bus.mem_enable) obs.en_count++;
                @(negedge clock);
                if (bus.mem_enable) obs.en_count++;
                done = 1'b1;
            end else begin
                if (bus.req_ready) obs.ready_low = 1'b0;
                @(negedge clock); cyc++;
            end
        end
        obs.timeout = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({bus.req_ready, bus.mem_enable} !== 2'b00) begin
            n_fail++; $display("FAIL reset_high_ready_enable: got %b want 00", {bus.req_ready, bus.mem_enable});
        end
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({bus.req_ready, bus.resp_valid, bus.mem_enable, bus.mem_wen, bus.resp_err} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 10000",
                               {bus.req_ready, bus.resp_valid, bus.mem_enable, bus.mem_wen, bus.resp_err});
        end
        n_tests++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_mask, bus.resp_data} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h mask %h resp %h want all 0",
                               bus.mem_addr, bus.mem_wdata, bus.mem_mask, bus.resp_data);
        end
    endtask

    task automatic test_store_byte();
        run_txn(1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hAB, 64'h0, 0);
        n_tests++;
        if (obs.addr !== 64'h8000_0000) begin n_fail++; $display("FAIL sb_addr: got %h want 80000000", obs.addr); end
        n_tests++;
        if (obs.mask !== 8'h08) begin n_fail++; $display("FAIL sb_mask: got %h want 08", obs.mask); end
        n_tests++;
        if (obs.wdata !== 64'h0000_0000_AB00_0000) begin
            n_fail++; $display("FAIL sb_wdata: got %h want 00000000ab000000", obs.wdata);
        end
        n_tests++;
        if ({obs.wen, obs.en_count} !== {1'b1, 32'd1}) begin
            n_fail++; $display("FAIL sb_wen_pulses: wen %b pulses %0d want wen 1 pulses 1", obs.wen, obs.en_count);
        end
        n_tests++;
        if (obs.latency !== 2) begin n_fail++; $display("FAIL sb_latency: got %0d want 2", obs.latency); end
    endtask

    task automatic test_load_half_signed();
        run_txn(1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'h0, 64'h8123_0000_0000_0000, 0);
        n_tests++;
        if (obs.data !== 64'hFFFF_FFFF_FFFF_8123) begin
            n_fail++; $display("FAIL lh_data: got %h want ffffffffffff8123", obs.data);
        end
        n_tests++;
        if (obs.latency !== 3) begin n_fail++; $display("FAIL lh_latency: got %0d want 3", obs.latency); end
        n_tests++;
        if ({obs.wen, obs.mask} !== {1'b0, 8'hC0}) begin
            n_fail++; $display("FAIL lh_wen_mask: got wen %b mask %h want wen 0 mask c0", obs.wen, obs.mask);
        end
    endtask

    task automatic test_load_word_unsigned();
        run_txn(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0, 64'hF000_0001_DEAD_BEEF, 0);
        n_tests++;
        if (obs.data !== 64'h0000_0000_F000_0001) begin
            n_fail++; $display("FAIL lw_data: got %h want 00000000f0000001", obs.data);
        end
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'h0, 64'h1122_3344_5566_7788, 5);
        n_tests++;
        if (!obs.stable) begin n_fail++; $display("FAIL bp_stable: got unstable want stable"); end
        n_tests++;
        if (!obs.ready_low) begin n_fail++; $display("FAIL bp_req_ready: got 1 in RESP want 0"); end
        n_tests++;
        if (!obs.idle_after || obs.en_count !== 1) begin
            n_fail++; $display("FAIL bp_return: idle %0d pulses %0d want idle 1 pulses 1", obs.idle_after, obs.en_count);
        end
        n_tests++;
        if (obs.data !== 64'h1122_3344_5566_7788) begin
            n_fail++; $display("FAIL bp_data: got %h want 1122334455667788", obs.data);
        end
    endtask

    task automatic test_reset_in_issue();
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'd3; bus.req_signed = 1'b0;
        bus.req_addr = 64'h8000_0020; bus.req_wdata = 64'hCAFE_F00D_1234_5678;
        @(negedge clock);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.mem_enable, bus.mem_wen} !== 2'b00) begin
            n_fail++; $display("FAIL rst_issue_enable: got %b want 00", {bus.mem_enable, bus.mem_wen});
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.req_ready, bus.resp_valid, bus.mem_enable, bus.mem_wen, bus.resp_err} !== 5'b10000 ||
            {bus.mem_addr, bus.mem_wdata, bus.mem_mask, bus.resp_data} !== '0) begin
            n_fail++; $display("FAIL rst_issue_outputs: ready %b rv %b en %b addr %h mask %h want reset values",
                               bus.req_ready, bus.resp_valid, bus.mem_enable, bus.mem_addr, bus.mem_mask);
        end
        repeat (2) @(negedge clock);
        n_tests++;
        if ({bus.resp_valid, bus.mem_enable} !== 2'b00) begin
            n_fail++; $display("FAIL rst_issue_dropped: got %b want 00", {bus.resp_valid, bus.mem_enable});
        end
    endtask

    task automatic test_dword_misaligned();
        logic [63:0] rd;
        rd = {$urandom, $urandom};
        run_txn(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'h0, rd, 0);
        n_tests++;
        if (obs.err !== TRAP) begin n_fail++; $display("FAIL mis_err: got %b want %b", obs.err, TRAP); end
        n_tests++;
        if (obs.en_count !== (TRAP ? 0 : 1)) begin
            n_fail++; $display("FAIL mis_enable: got %0d pulses want %0d", obs.en_count, TRAP ? 0 : 1);
        end
        n_tests++;
        if (obs.latency !== (TRAP ? 1 : 3)) begin
            n_fail++; $display("FAIL mis_latency: got %0d want %0d", obs.latency, TRAP ? 1 : 3);
        end
        n_tests++;
        if (obs.data !== (TRAP ? 64'h0 : m_load(rd, 3, 4, 1'b0))) begin
            n_fail++; $display("FAIL mis_data: got %h", obs.data);
        end
        if (!TRAP) begin
            n_tests++;
            if (obs.mask !== 8'hF0) begin n_fail++; $display("FAIL mis_mask: got %h want f0", obs.mask); end
        end
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            logic        st, sg;
            logic [1:0]  sz;
            logic [63:0] ad, wd, rd, exp_data;
            bit          trapped;
            int          off, exp_lat;
            st = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom);
            ad = 64'h8000_0000 + 64'($urandom_range(0, 4095));
            wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
            off = int'(ad[2:0]);
            trapped = TRAP && m_misaligned(ad, int'(sz));
            run_txn(st, sz, sg, ad, wd, rd, $urandom_range(0, 2));
            exp_lat  = trapped ? 1 : (st ? 2 : 3);
            exp_data = (trapped || st) ? 64'h0 : m_load(rd, int'(sz), off, sg);
            n_tests++;
            if (obs.timeout || !obs.ready_at_req) begin
                n_fail++; $display("FAIL rnd%0d_handshake: timeout %0d ready %0d", t, obs.timeout, obs.ready_at_req);
            end
            n_tests++;
            if (obs.latency !== exp_lat) begin
                n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, obs.latency, exp_lat);
            end
            n_tests++;
            if (obs.data !== exp_data || obs.err !== trapped) begin
                n_fail++; $display("FAIL rnd%0d_resp: got %h err %b want %h err %b", t, obs.data, obs.err, exp_data, trapped);
            end
            n_tests++;
            if (obs.en_count !== (trapped ? 0 : 1)) begin
                n_fail++; $display("FAIL rnd%0d_pulses: got %0d want %0d", t, obs.en_count, trapped ? 0 : 1);
            end
            n_tests++;
            if (!obs.stable || !obs.ready_low || !obs.idle_after) begin
                n_fail++; $display("FAIL rnd%0d_protocol: stable %0d ready_low %0d idle %0d want 1 1 1",
                                   t, obs.stable, obs.ready_low, obs.idle_after);
            end
            if (!trapped) begin
                n_tests++;
                if (obs.addr !== (ad & ~64'h7) || obs.mask !== m_mask(int'(sz), off) ||
                    obs.wdata !== m_wdata(wd, off) || obs.wen !== st) begin
                    n_fail++; $display("FAIL rnd%0d_bus: addr %h mask %h wdata %h wen %b want %h %h %h %b", t,
                                       obs.addr, obs.mask, obs.wdata, obs.wen,
                                       ad & ~64'h7, m_mask(int'(sz), off), m_wdata(wd, off), st);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0; bus.resp_ready = 1'b0;
        test_reset();
        test_store_byte();
        test_load_half_signed();
        test_load_word_unsigned();
        test_backpressure();
        test_reset_in_issue();
        test_dword_misaligned();
        test_random(60);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
